// File: rtl/main_mem_responder.sv
// main_mem_responder
//   Main-memory side of the cache refill / write-through interface. Accepts
//   one request at a time. A read returns a whole block-aligned cache block
//   as a BLOCK_WORDS-beat burst (lowest word first). A write commits a single
//   word and answers with one acknowledge beat. A fixed access latency of
//   LATENCY idle cycles sits between accept and the first response beat.
//
//   Ports
//     clk, rst            rising-edge clock, asynchronous active-high reset
//     req_valid/req_ready request handshake (ready only while idle)
//     req_write           1 = write one word, 0 = block refill read
//     req_addr            byte address; word index = addr[log2(DEPTH)+1:2]
//     req_wdata           write data
//     resp_valid/ready    response beat handshake
//     resp_data           read data, 0 on a write acknowledge
//     resp_last           marks the final beat of a response
//
//   INIT_FILE is kept for interface compatibility only. This model has no
//   preload path: contents start undefined and are set through writes.
module main_mem_responder #(
  parameter int    ADDR_WIDTH  = 32,
  parameter int    DATA_WIDTH  = 32,
  parameter int    DEPTH_WORDS = 1024,
  parameter int    BLOCK_WORDS = 2,
  parameter int    LATENCY     = 4,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_last
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int OFF_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [IDX_W-1:0] BLK_MASK  = IDX_W'(BLOCK_WORDS - 1);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_END   = CNT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);
  localparam bit unused_init_given = (INIT_FILE != "");

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH_WORDS];

  state_t                state_r, state_next_s;
  logic [CNT_W-1:0]      cnt_r, cnt_next_s;
  logic [OFF_W-1:0]      beat_r, beat_next_s;
  logic [IDX_W-1:0]      idx_r, idx_next_s;
  logic                  write_r, write_next_s;
  logic [DATA_WIDTH-1:0] wdata_r, wdata_next_s;
  logic                  req_ready_r, req_ready_next_s;
  logic                  resp_valid_r, resp_valid_next_s;
  logic [DATA_WIDTH-1:0] resp_data_r, resp_data_next_s;
  logic                  resp_last_r, resp_last_next_s;

  logic [IDX_W-1:0]      req_idx_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic [DATA_WIDTH-1:0] mem_rdata_s;
  logic                  start_s;
  logic                  start_write_s;
  logic [IDX_W-1:0]      start_idx_s;
  logic [DATA_WIDTH-1:0] start_wdata_s;
  logic                  mem_we_s;
  logic [IDX_W-1:0]      mem_widx_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic                  unused_addr_bits_s;

  assign req_idx_s          = req_addr[IDX_W+1:2];
  assign unused_addr_bits_s = ^{req_addr[1:0], req_addr[ADDR_WIDTH-1:IDX_W+2]};
  assign mem_rdata_s        = mem_r[rd_idx_s];

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_last  = resp_last_r;

  // Read address: the first beat of a burst starting now (from IDLE or WAIT),
  // or the beat after the current one while streaming in RESP.
  always_comb begin
    rd_idx_s = idx_r & ~BLK_MASK;
    case (state_r)
      IDLE:    rd_idx_s = req_idx_s & ~BLK_MASK;
      WAIT:    rd_idx_s = idx_r & ~BLK_MASK;
      RESP:    rd_idx_s = (idx_r & ~BLK_MASK) + IDX_W'(beat_r) + {{(IDX_W-1){1'b0}}, 1'b1};
      default: rd_idx_s = idx_r & ~BLK_MASK;
    endcase
  end

  // Next-state and next-output logic; all outputs are registered.
  always_comb begin
    state_next_s      = state_r;
    cnt_next_s        = cnt_r;
    beat_next_s       = beat_r;
    idx_next_s        = idx_r;
    write_next_s      = write_r;
    wdata_next_s      = wdata_r;
    resp_valid_next_s = resp_valid_r;
    resp_data_next_s  = resp_data_r;
    resp_last_next_s  = resp_last_r;
    start_s           = 1'b0;
    start_write_s     = write_r;
    start_idx_s       = idx_r;
    start_wdata_s     = wdata_r;
    mem_we_s          = 1'b0;
    mem_widx_s        = idx_r;
    mem_wdata_s       = wdata_r;

    case (state_r)
      IDLE: begin
        if (req_valid && req_ready_r) begin
          idx_next_s   = req_idx_s;
          write_next_s = req_write;
          wdata_next_s = req_wdata;
          if (LATENCY == 0) begin
            // Zero latency: the accept edge is also the first-beat edge.
            start_s       = 1'b1;
            start_write_s = req_write;
            start_idx_s   = req_idx_s;
            start_wdata_s = req_wdata;
          end else begin
            state_next_s = WAIT;
            cnt_next_s   = {CNT_W{1'b0}};
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == CNT_END) begin
          start_s = 1'b1;
        end else begin
          cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      RESP: begin
        if (resp_ready) begin
          if (resp_last_r) begin
            state_next_s      = IDLE;
            resp_valid_next_s = 1'b0;
            resp_data_next_s  = {DATA_WIDTH{1'b0}};
            resp_last_next_s  = 1'b0;
          end else begin
            beat_next_s      = beat_r + {{(OFF_W-1){1'b0}}, 1'b1};
            resp_data_next_s = mem_rdata_s;
            resp_last_next_s = (beat_next_s == LAST_BEAT);
          end
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s      = IDLE;
        resp_valid_next_s = 1'b0;
        resp_data_next_s  = {DATA_WIDTH{1'b0}};
        resp_last_next_s  = 1'b0;
      end
    endcase

    // First beat: a write commits here and acknowledges; a read fetches word 0.
    if (start_s) begin
      state_next_s      = RESP;
      resp_valid_next_s = 1'b1;
      beat_next_s       = {OFF_W{1'b0}};
      if (start_write_s) begin
        mem_we_s         = 1'b1;
        mem_widx_s       = start_idx_s;
        mem_wdata_s      = start_wdata_s;
        resp_data_next_s = {DATA_WIDTH{1'b0}};
        resp_last_next_s = 1'b1;
      end else begin
        resp_data_next_s = mem_rdata_s;
        resp_last_next_s = (BLOCK_WORDS == 1) ? 1'b1 : 1'b0;
      end
    end else begin
      mem_we_s = 1'b0;
    end

    req_ready_next_s = (state_next_s == IDLE);
  end

  // State, latched request and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      beat_r       <= {OFF_W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      write_r      <= 1'b0;
      wdata_r      <= {DATA_WIDTH{1'b0}};
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_data_r  <= {DATA_WIDTH{1'b0}};
      resp_last_r  <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      cnt_r        <= cnt_next_s;
      beat_r       <= beat_next_s;
      idx_r        <= idx_next_s;
      write_r      <= write_next_s;
      wdata_r      <= wdata_next_s;
      req_ready_r  <= req_ready_next_s;
      resp_valid_r <= resp_valid_next_s;
      resp_data_r  <= resp_data_next_s;
      resp_last_r  <= resp_last_next_s;
    end
  end

  // Backing store, not reset; a write is dropped while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_r[mem_widx_s] <= mem_wdata_s;
    end
  end

endmodule
